// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with request-to-send, ack check and timeout
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6500,
    parameter int TIMEOUT_CYCLES = 975000,
    parameter int CNT_W          = 20
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE} state_t;

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_PRE  = CNT_W'(TIMEOUT_CYCLES - 2);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       bitcnt, bitcnt_n;
    logic [9:0]       frame, frame_n;
    logic             clk_oe_n, data_oe_n;
    logic [2:0]       clk_sync;
    logic [1:0]       data_sync;
    logic             fall, timed, tmo;

    assign fall     = clk_sync[2] & ~clk_sync[1];
    assign timed    = (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
    assign tmo      = timed && (cnt == TMO_LAST);
    assign tx_ready = (state == IDLE);
    assign busy     = ~tx_ready;
    assign done     = (state == WAIT_IDLE) && clk_sync[1] && data_sync[1] && !tmo;
    assign err      = tmo || ((state == ACK) && fall && data_sync[1]);

    // Bring the asynchronous pad levels into the pclk domain; clk keeps one history stage for edge detection.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
        end
    end

    // State, counters, frame and the registered pad enables; reset releases both lines at once.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bitcnt      <= '0;
            frame       <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bitcnt      <= bitcnt_n;
            frame       <= frame_n;
            ps2_clk_oe  <= clk_oe_n;
            ps2_data_oe <= data_oe_n;
        end
    end

    // Next-state logic; data is released one cycle ahead of the timeout so the err cycle already sees a floating bus.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bitcnt_n  = bitcnt;
        frame_n   = frame;
        clk_oe_n  = ps2_clk_oe;
        data_oe_n = ps2_data_oe;
        case (state)
            IDLE: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                if (tx_valid) begin
                    state_n  = INHIBIT;
                    frame_n  = {1'b1, ~^tx_data, tx_data};
                    bitcnt_n = '0;
                    cnt_n    = '0;
                    clk_oe_n = 1'b1;
                end
            end
            INHIBIT: begin
                clk_oe_n  = 1'b1;
                data_oe_n = 1'b0;
                if (cnt == INH_LAST) begin
                    state_n   = RTS;
                    cnt_n     = '0;
                    data_oe_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            RTS: begin
                state_n   = SEND;
                cnt_n     = '0;
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b1;
            end
            SEND: begin
                cnt_n = cnt + CNT_W'(1);
                if (fall) begin
                    if (bitcnt == 4'd9) begin
                        data_oe_n = 1'b0;
                        bitcnt_n  = 4'd10;
                        state_n   = ACK;
                    end else begin
                        data_oe_n = ~frame[bitcnt];
                        bitcnt_n  = bitcnt + 4'd1;
                    end
                end
            end
            ACK: begin
                cnt_n = cnt + CNT_W'(1);
                if (fall) state_n = data_sync[1] ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                cnt_n = cnt + CNT_W'(1);
                if (clk_sync[1] && data_sync[1]) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (timed && (cnt == TMO_PRE)) data_oe_n = 1'b0;
        if (tmo) begin
            state_n   = IDLE;
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a PS/2 device model clocking one fall per 40 pclk
module tb_ps2_host_tx;

    logic       pclk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, err;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    int checks = 0;
    int fails = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int ready_bad = 0;
    int rel_cnt = 0;
    int err_rel = 0;
    int acc_cnt = 0;
    logic [1:0] err_oe = 2'b00;
    logic pulse_prev = 1'b0;

    assign ps2_clk_in  = ~ps2_clk_oe & ~dev_clk_low;
    assign ps2_data_in = ~ps2_data_oe & ~dev_data_low;

    ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(5000), .CNT_W(20)) dut (
        .pclk(pclk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in), .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe), .busy(busy), .done(done), .err(err)
    );

    always #5 pclk = ~pclk;

    // Pulse bookkeeping, accept counting and release-to-err distance, sampled on the active edge.
    always @(posedge pclk) begin
        rel_cnt    <= tx_ready ? 0 : (!ps2_clk_oe ? rel_cnt + 1 : rel_cnt);
        pulse_prev <= done | err;
        if (err) begin
            err_cnt <= err_cnt + 1;
            err_rel <= rel_cnt + 1;
            err_oe  <= {ps2_clk_oe, ps2_data_oe};
        end
        if (done) done_cnt <= done_cnt + 1;
        if (done && err) both_cnt <= both_cnt + 1;
        if (((done | err) && tx_ready) || (pulse_prev && !tx_ready)) ready_bad <= ready_bad + 1;
        if (tx_valid && tx_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input bit hold, output int hi);
        @(negedge pclk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge pclk);
        if (!hold) tx_valid = 1'b0;
        check("ready_drop", tx_ready, 0);
        hi = 0;
        while (ps2_clk_oe === 1'b1 && hi < 200) begin
            hi++;
            @(negedge pclk);
        end
    endtask

    task automatic frame(input int nf, input bit ack, output logic [10:0] bits);
        int w;
        w = 0;
        bits = '0;
        while (ps2_clk_oe !== 1'b0 && w < 200) begin
            w++;
            @(negedge pclk);
        end
        for (int k = 0; k < nf; k++) begin
            repeat (20) @(negedge pclk);
            bits[k] = ps2_data_in;
            if (k == 10) begin
                dev_data_low = ack;
                repeat (5) @(negedge pclk);
            end
            dev_clk_low = 1'b1;
            repeat (20) @(negedge pclk);
            dev_clk_low = 1'b0;
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_pulse(input int d0, input int e0, input int lim);
        for (int i = 0; i < lim && done_cnt == d0 && err_cnt == e0; i++) @(negedge pclk);
        repeat (2) @(negedge pclk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] b;
        int hi, d0, e0, a0;
        repeat (3) @(negedge pclk);
        check("reset_state", {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err}, 6'b100000);
        reset = 1'b0;
        repeat (3) @(negedge pclk);

        d0 = done_cnt; e0 = err_cnt;
        send(8'hF4, 0, hi);
        check("f4_inhibit_len", hi, 21);
        frame(11, 1, b);
        check("f4_bits", b, {1'b1, 1'b0, 8'hF4, 1'b0});
        wait_pulse(d0, e0, 200);
        check("f4_done", done_cnt - d0, 1);
        check("f4_err", err_cnt - e0, 0);

        d0 = done_cnt; e0 = err_cnt;
        send(8'hFF, 0, hi);
        frame(11, 1, b);
        check("ff_bits", b, {1'b1, 1'b1, 8'hFF, 1'b0});
        wait_pulse(d0, e0, 200);
        check("ff_done", done_cnt - d0, 1);

        d0 = done_cnt; e0 = err_cnt;
        send(8'h00, 0, hi);
        frame(11, 0, b);
        check("nack_bits", b, {1'b1, 1'b1, 8'h00, 1'b0});
        wait_pulse(d0, e0, 200);
        check("nack_err", err_cnt - e0, 1);
        check("nack_done", done_cnt - d0, 0);
        check("nack_ready", tx_ready, 1);

        d0 = done_cnt; e0 = err_cnt;
        send(8'hF4, 0, hi);
        frame(4, 1, b);
        check("tmo_bits", b[3:0], 4'b1000);
        check("tmo_driving", ps2_data_oe, 1);
        wait_pulse(d0, e0, 6000);
        check("tmo_err", err_cnt - e0, 1);
        check("tmo_done", done_cnt - d0, 0);
        check("tmo_distance", err_rel, 5000);
        check("tmo_oe", err_oe, 2'b00);

        send(8'h00, 0, hi);
        frame(6, 1, b);
        check("rst_bits", b[5:0], 6'b000000);
        check("rst_pre_oe", ps2_data_oe, 1);
        reset = 1'b1;
        #1;
        check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("rst_busy", busy, 0);
        check("rst_ready", tx_ready, 1);
        repeat (2) @(negedge pclk);
        reset = 1'b0;
        repeat (3) @(negedge pclk);
        d0 = done_cnt; e0 = err_cnt;
        send(8'hF4, 0, hi);
        check("post_rst_inhibit_len", hi, 21);
        frame(11, 1, b);
        check("post_rst_bits", b, {1'b1, 1'b0, 8'hF4, 1'b0});
        wait_pulse(d0, e0, 200);
        check("post_rst_done", done_cnt - d0, 1);

        a0 = acc_cnt; d0 = done_cnt;
        send(8'hE8, 1, hi);
        frame(11, 1, b);
        check("e8_bits", b, {1'b1, 1'b1, 8'hE8, 1'b0});
        for (int i = 0; i < 200 && done_cnt == d0; i++) @(negedge pclk);
        check("e8_single_accept", acc_cnt - a0, 1);
        @(negedge pclk);
        check("e8_second_accept", acc_cnt - a0, 2);
        tx_valid = 1'b0;
        d0 = done_cnt; e0 = err_cnt;
        frame(11, 1, b);
        check("e8_again_bits", b, {1'b1, 1'b1, 8'hE8, 1'b0});
        wait_pulse(d0, e0, 200);
        check("e8_again_done", done_cnt - d0, 1);

        check("ready_after_pulse", ready_bad, 0);
        check("done_err_overlap", both_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
